tpm_sync_controller: RTL and testbench
======================================

// Module: tpm_sync_controller
// PURPOSE
// Sequences two tree-parity-machine partner instances through a key exchange.
// Steps: weight init, then repeated rounds of compute, output compare and learn.
// Drives the shared 3-bit ctrl code and the shared K*N-bit feed vector.
// Declares sync after SYNC_ROUNDS consecutive agreeing rounds, or timeout after MAX_ROUNDS.
// PARAMETERS
// K            2      hidden units per partner
// N            3      inputs per hidden unit; feed width = K*N
// SYNC_ROUNDS  16     consecutive agreeing rounds required to declare sync
// MAX_ROUNDS   1024   round limit before timeout
// RW           16     width of round counter (must hold MAX_ROUNDS)
// FEED_SEED    16'hACE1  reset value of internal 16-bit feed LFSR (nonzero)
// PORTS
// clk        in   1      system clock, rising edge
// rst_n      in   1      asynchronous active-low reset
// start      in   1      pulse: begin exchange (honoured only in IDLE/DONE/FAIL)
// out_a      in   1      parity output of partner A
// out_b      in   1      parity output of partner B
// ctrl       out  3      phase code to both partners: 000 idle, 001 init, 010 compute, 100 learn, 111 synced
// feed       out  K*N    shared input vector to both partners
// busy       out  1      high from INIT through LEARN
// synced     out  1      high in DONE
// timeout    out  1      high in FAIL
// round_cnt  out  RW     completed rounds since start
// agree_cnt  out  8      current run of consecutive agreeing rounds
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, ctrl=000, feed=0, LFSR=FEED_SEED; all flags and counters 0.
// - All outputs are registered. Partners see a ctrl value one edge after it appears.
// - Partners act on rising edges of ctrl bits, so every phase change alters ctrl.
// - States and ctrl per state:
//   IDLE(000), INIT(001), GAP(000), COMPUTE(010), CHECK(010), LEARN(100), DONE(111), FAIL(000).
// - IDLE: on start go to INIT. Clear round_cnt and agree_cnt. Load cyc_cnt=K*N.
// - INIT: hold 001 for exactly K*N cycles (one weight per partner edge), then go to GAP.
// - GAP: 1 cycle. Advance LFSR one step and load feed = LFSR[K*N-1:0].
//   feed then stays constant until the next GAP. Go to COMPUTE with cyc_cnt=K*N.
// - COMPUTE: hold 010 for exactly K*N cycles, then go to CHECK.
// - CHECK: 1 cycle, ctrl stays 010. Sample out_a and out_b here.
//   equal -> agree_cnt+1 (saturate at 255); unequal -> agree_cnt=0.
// - LEARN: 1 cycle of 100. It is always issued; partners skip learning internally on mismatch.
//   Then round_cnt+1.
// - After LEARN, check in this order:
//   1. agree_cnt >= SYNC_ROUNDS -> DONE.
//   2. else round_cnt == MAX_ROUNDS -> FAIL.
//   3. else -> GAP.
// - Round length = K*N+3 cycles. feed is stable from GAP through LEARN.
// - DONE: ctrl=111 held, synced=1. start -> INIT, clears synced and counters.
// - FAIL: ctrl=000, timeout=1. start -> INIT, clears timeout and counters.
// - start while busy: ignored. out_a/out_b are ignored outside CHECK.
// - LFSR: x^16+x^14+x^13+x^11+1, Fibonacci. It steps only in GAP, so the feed sequence is deterministic from reset.
// - rst_n low mid-round: immediate return to IDLE and ctrl=000.
//   The bench must also reset the partners; a restart always re-runs INIT.
// - cyc_cnt width: clog2(K*N+1). Compares are unsigned.
// TESTING
// - Reset then start with K=2,N=3:
//   ctrl sequence 000 -> 001 x6 -> 000 x1 -> 010 x7 (COMPUTE+CHECK) -> 100 x1 -> 000.
// - Drive out_a==out_b every CHECK with SYNC_ROUNDS=4:
//   DONE after round 4, ctrl=111, synced=1, round_cnt=4.
// - Alternate agree/disagree with MAX_ROUNDS=8:
//   agree_cnt toggles 1,0,1,0...; FAIL after 8 rounds, timeout=1, ctrl=000.
// - start pulsed during COMPUTE: no state change and no counter change.
// - rst_n asserted in the 3rd COMPUTE cycle: IDLE next, ctrl=000, feed=0.
//   A later start reproduces the identical feed sequence.
// - Two real partner instances (seeds 1 and 2) plus a weight-compare monitor:
//   on DONE, all K*N weights of both partners are equal.

Source files
------------

// File: rtl/tpm_sync_controller.sv
// Sequences two tree-parity-machine partners through a key exchange:
// weight init, then GAP/COMPUTE/CHECK/LEARN rounds until sync or round limit.
module tpm_sync_controller #(
    parameter int unsigned K           = 2,
    parameter int unsigned N           = 3,
    parameter int unsigned SYNC_ROUNDS = 16,
    parameter int unsigned MAX_ROUNDS  = 1024,
    parameter int unsigned RW          = 16,
    parameter logic [15:0] FEED_SEED   = 16'hACE1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_out_a,
    input  logic           i_out_b,
    output logic [2:0]     o_ctrl,
    output logic [K*N-1:0] o_feed,
    output logic           o_busy,
    output logic           o_synced,
    output logic           o_timeout,
    output logic [RW-1:0]  o_round_cnt,
    output logic [7:0]     o_agree_cnt
);
    localparam int unsigned KN = K * N;
    localparam int unsigned CW = $clog2(KN + 1);
    localparam logic [CW-1:0] CycLoad  = CW'(KN);
    localparam logic [RW-1:0] RoundMax = RW'(MAX_ROUNDS);

    typedef enum logic [2:0] {
        StIdle, StInit, StGap, StCompute, StCheck, StLearn, StDone, StFail
    } state_e;

    state_e        r_state, w_state_next;
    logic [CW-1:0] r_cyc, w_cyc_next;
    logic [15:0]   r_lfsr, w_lfsr_next;
    logic [KN-1:0] r_feed, w_feed_next;
    logic [RW-1:0] r_round, w_round_next, w_round_inc;
    logic [7:0]    r_agree, w_agree_next;
    logic [2:0]    r_ctrl, w_ctrl_next;
    logic          r_busy, r_synced, r_timeout;
    logic          w_busy_next, w_synced_next, w_timeout_next;

    always_comb begin
        w_state_next = r_state;
        w_cyc_next   = r_cyc;
        w_lfsr_next  = r_lfsr;
        w_feed_next  = r_feed;
        w_round_next = r_round;
        w_agree_next = r_agree;
        w_round_inc  = r_round + RW'(1);
        unique case (r_state)
            StIdle, StDone, StFail: begin
                if (i_start) begin
                    w_state_next = StInit;
                    w_cyc_next   = CycLoad;
                    w_round_next = '0;
                    w_agree_next = '0;
                end
            end
            StInit: begin
                if (r_cyc == CW'(1)) w_state_next = StGap;
                else                 w_cyc_next   = r_cyc - CW'(1);
            end
            StGap: begin
                w_state_next = StCompute;
                w_cyc_next   = CycLoad;
            end
            StCompute: begin
                if (r_cyc == CW'(1)) w_state_next = StCheck;
                else                 w_cyc_next   = r_cyc - CW'(1);
            end
            StCheck: begin
                w_state_next = StLearn;
                if (i_out_a == i_out_b) begin
                    w_agree_next = (r_agree == 8'hFF) ? r_agree : r_agree + 8'd1;
                end else begin
                    w_agree_next = '0;
                end
            end
            StLearn: begin
                w_round_next = w_round_inc;
                if (32'(r_agree) >= SYNC_ROUNDS)  w_state_next = StDone;
                else if (w_round_inc == RoundMax) w_state_next = StFail;
                else                              w_state_next = StGap;
            end
            default: w_state_next = StIdle;
        endcase

        // Stepping on entry to GAP makes feed stable for the whole round, GAP included.
        if (w_state_next == StGap) begin
            w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
            w_feed_next = w_lfsr_next[KN-1:0];
        end

        w_ctrl_next    = 3'b000;
        w_busy_next    = 1'b0;
        w_synced_next  = 1'b0;
        w_timeout_next = 1'b0;
        unique case (w_state_next)
            StInit:   begin w_ctrl_next = 3'b001; w_busy_next = 1'b1; end
            StGap:    w_busy_next = 1'b1;
            StCompute,
            StCheck:  begin w_ctrl_next = 3'b010; w_busy_next = 1'b1; end
            StLearn:  begin w_ctrl_next = 3'b100; w_busy_next = 1'b1; end
            StDone:   begin w_ctrl_next = 3'b111; w_synced_next = 1'b1; end
            StFail:   w_timeout_next = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_cyc     <= '0;
            r_lfsr    <= FEED_SEED;
            r_feed    <= '0;
            r_round   <= '0;
            r_agree   <= '0;
            r_ctrl    <= 3'b000;
            r_busy    <= 1'b0;
            r_synced  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cyc     <= w_cyc_next;
            r_lfsr    <= w_lfsr_next;
            r_feed    <= w_feed_next;
            r_round   <= w_round_next;
            r_agree   <= w_agree_next;
            r_ctrl    <= w_ctrl_next;
            r_busy    <= w_busy_next;
            r_synced  <= w_synced_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign o_ctrl      = r_ctrl;
    assign o_feed      = r_feed;
    assign o_busy      = r_busy;
    assign o_synced    = r_synced;
    assign o_timeout   = r_timeout;
    assign o_round_cnt = r_round;
    assign o_agree_cnt = r_agree;

endmodule

// File: tb/tb_tpm_sync_controller.sv
// Scoreboard bench: a cycle-index model predicts every output each cycle,
// a negedge monitor pops and compares.
module tb_tpm_sync_controller;
    localparam int KN   = 6;
    localparam int SYNC = 4;
    localparam int MAXR = 8;
    localparam int RW   = 16;
    localparam int RLEN = KN + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_a = 1'b0;
    logic          out_b = 1'b0;
    logic [2:0]    ctrl;
    logic [KN-1:0] feed;
    logic          busy, synced, timeout;
    logic [RW-1:0] round_cnt;
    logic [7:0]    agree_cnt;

    tpm_sync_controller #(
        .K(2), .N(3), .SYNC_ROUNDS(SYNC), .MAX_ROUNDS(MAXR), .RW(RW), .FEED_SEED(16'hACE1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_out_a(out_a), .i_out_b(out_b),
        .o_ctrl(ctrl), .o_feed(feed), .o_busy(busy), .o_synced(synced),
        .o_timeout(timeout), .o_round_cnt(round_cnt), .o_agree_cnt(agree_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    ctrl;
        logic [KN-1:0] feed;
        logic          busy;
        logic          synced;
        logic          timeout;
        logic [RW-1:0] round;
        logic [7:0]    agree;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Model: 0 idle, 1 running, 2 done, 3 fail; m_t counts cycles since INIT began.
    int          m_st, m_t, m_round, m_agree;
    logic [15:0] m_lfsr;
    logic [KN-1:0] m_feed;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int   taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        for (int i = 0; i < 4; i++) fb ^= s[16 - taps[i]];
        return {fb, s[15:1]};
    endfunction

    function automatic void model_reset();
        m_st = 0; m_t = 0; m_round = 0; m_agree = 0;
        m_lfsr = 16'hACE1; m_feed = '0;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        int   ph;
        e = '0;
        e.feed  = m_feed;
        e.round = RW'(m_round);
        e.agree = 8'(m_agree);
        case (m_st)
            1: begin
                e.busy = 1'b1;
                if (m_t < KN) e.ctrl = 3'b001;
                else begin
                    ph = (m_t - KN) % RLEN;
                    if (ph == 0)            e.ctrl = 3'b000;
                    else if (ph <= KN + 1)  e.ctrl = 3'b010;
                    else                    e.ctrl = 3'b100;
                end
            end
            2: begin e.ctrl = 3'b111; e.synced = 1'b1; end
            3: e.timeout = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit is_check();
        return m_st == 1 && m_t >= KN && (m_t - KN) % RLEN == KN + 1;
    endfunction

    function automatic void model_step(input bit st, input bit a, input bit b);
        int ph;
        if (m_st != 1) begin
            if (st) begin m_st = 1; m_t = 0; m_round = 0; m_agree = 0; end
            return;
        end
        ph = (m_t < KN) ? -1 : (m_t - KN) % RLEN;
        if (ph == KN + 1) m_agree = (a == b) ? ((m_agree < 255) ? m_agree + 1 : 255) : 0;
        if (ph == KN + 2) begin
            m_round++;
            if (m_agree >= SYNC) begin m_st = 2; return; end
            if (m_round == MAXR) begin m_st = 3; return; end
        end
        m_t++;
        if (m_t >= KN && (m_t - KN) % RLEN == 0) begin
            m_lfsr = lfsr_step(m_lfsr);
            m_feed = m_lfsr[KN-1:0];
        end
    endfunction

    task automatic tick(input bit st, input bit a, input bit b);
        @(posedge clk);
        #1;
        sb_q.push_back(model_expect());
        start = st; out_a = a; out_b = b;
        model_step(st, a, b);
    endtask

    always @(negedge clk) begin
        if (rst_n && sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("ctrl",      32'(ctrl),      32'(mon_e.ctrl));
            chk("feed",      32'(feed),      32'(mon_e.feed));
            chk("busy",      32'(busy),      32'(mon_e.busy));
            chk("synced",    32'(synced),    32'(mon_e.synced));
            chk("timeout",   32'(timeout),   32'(mon_e.timeout));
            chk("round_cnt", 32'(round_cnt), 32'(mon_e.round));
            chk("agree_cnt", 32'(agree_cnt), 32'(mon_e.agree));
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"},  32'(ctrl),      32'd0);
        chk({tag, "_feed"},  32'(feed),      32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_flags"}, 32'({synced, timeout}), 32'd0);
        chk({tag, "_round"}, 32'(round_cnt), 32'd0);
        chk({tag, "_agree"}, 32'(agree_cnt), 32'd0);
    endtask

    // Asynchronous reset landing inside the cycle the model is about to enter.
    task automatic mid_reset();
        @(posedge clk);
        #1;
        chk("pre_reset_ctrl", 32'(ctrl), 32'(3'b010));
        #1;
        rst_n = 1'b0; start = 1'b0; out_a = 1'b0; out_b = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        sb_q.delete();
    endtask

    // mode 0: partners agree, 1: alternate agree/disagree, 2: random.
    task automatic run(input int mode, input int rst_at);
        bit a, b, st;
        int guard = 0;
        tick(1'b1, 1'b0, 1'b0);
        while (m_st == 1 && guard < 1000) begin
            if (rst_at > 0 && m_t == KN + rst_at) begin
                mid_reset();
                return;
            end
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if (is_check()) begin
                if (mode == 0)      b = a;
                else if (mode == 1) b = (m_round % 2 == 0) ? a : ~a;
            end
            st = ($urandom_range(0, 5) == 0);
            tick(st, a, b);
            guard++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        repeat (3) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        run(0, 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("sync_ctrl",   32'(ctrl),      32'(3'b111));
        chk("sync_flag",   32'(synced),    32'd1);
        chk("sync_rounds", 32'(round_cnt), 32'd4);
        repeat (2) tick(1'b0, 1'b1, 1'b0);

        run(1, 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("fail_ctrl",   32'(ctrl),      32'd0);
        chk("fail_flag",   32'(timeout),   32'd1);
        chk("fail_rounds", 32'(round_cnt), 32'd8);
        repeat (2) tick(1'b0, 1'b0, 1'b0);

        run(2, 3);
        repeat (2) tick(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run(2, 0);
            repeat (2) tick(1'b0, 1'b0, 1'b0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
